// File: rtl/ddr3_ddl_cmd.sv
// DDL command responder: registered DFI command pins, per-command timing stall, refresh tracking.
// Optional DDR3_REF_POSTPONE_EN: allow up to 8 postponed refreshes instead of a single pending flag.
module ddr3_ddl_cmd #(
    parameter int unsigned TRCD         = 2,
    parameter int unsigned TRP          = 2,
    parameter int unsigned TRFC         = 11,
    parameter int unsigned TMRD         = 4,
    parameter int unsigned TZQ          = 512,
    parameter int unsigned TCCD         = 4,
    parameter int unsigned TRDP         = 6,
    parameter int unsigned TWRP         = 13,
    parameter int unsigned TREFI        = 780,
    parameter int unsigned DDR_ROW_BITS = 13
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    ref_en_i,
    input  logic                    ddl_req_i,
    input  logic                    ddl_seq_i,
    output logic                    ddl_rdy_o,
    output logic                    ddl_ref_o,
    input  logic [2:0]              ddl_cmd_i,
    input  logic [2:0]              ddl_ba_i,
    input  logic [DDR_ROW_BITS-1:0] ddl_adr_i,
    output logic                    dfi_cs_n_o,
    output logic                    dfi_ras_n_o,
    output logic                    dfi_cas_n_o,
    output logic                    dfi_we_n_o,
    output logic [2:0]              dfi_ba_o,
    output logic [DDR_ROW_BITS-1:0] dfi_adr_o,
    output logic                    ddl_wr_o,
    output logic                    ddl_rd_o,
    output logic                    ref_err_o
);

    localparam logic [2:0] CmdMode = 3'b000;
    localparam logic [2:0] CmdRefr = 3'b001;
    localparam logic [2:0] CmdPrec = 3'b010;
    localparam logic [2:0] CmdActv = 3'b011;
    localparam logic [2:0] CmdWrit = 3'b100;
    localparam logic [2:0] CmdRead = 3'b101;
    localparam logic [2:0] CmdZqcl = 3'b110;
    localparam logic [2:0] CmdNoop = 3'b111;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MaxD = max_u(max_u(max_u(TRCD, TRP), max_u(TRFC, TMRD)),
                                         max_u(max_u(TZQ, TCCD), max_u(TRDP, TWRP)));
    localparam int unsigned TW   = $clog2(MaxD) + 1;
    localparam int unsigned RW   = (TREFI > 1) ? $clog2(TREFI) : 1;

`ifdef DDR3_REF_POSTPONE_EN
    localparam int unsigned PW   = 4;
    localparam int unsigned PMax = 8;
`else
    localparam int unsigned PW   = 1;
    localparam int unsigned PMax = 1;
`endif

    typedef enum logic [0:0] {StReady, StWait} state_e;

    state_e                  state_q, state_d;
    logic [TW-1:0]           cnt_q, cnt_d;
    logic                    rdy_q, rdy_d;
    logic [TW-1:0]           delay;
    logic                    accept;

    logic                    cs_n_q, cs_n_d;
    logic [2:0]              pins_q, pins_d;
    logic [2:0]              ba_q, ba_d;
    logic [DDR_ROW_BITS-1:0] adr_q, adr_d;
    logic                    wr_q, wr_d;
    logic                    rd_q, rd_d;

    logic [RW-1:0]           ref_cnt_q, ref_cnt_d;
    logic                    wrap_q, wrap_d;
    logic [PW-1:0]           pend_q, pend_d;
    logic                    ref_q, ref_d;
    logic                    err_q, err_d;
    logic                    refr_acc;

    assign accept   = ddl_req_i && rdy_q;
    assign refr_acc = accept && (ddl_cmd_i == CmdRefr);

    always_comb begin
        delay = TW'(1);
        case (ddl_cmd_i)
            CmdMode: delay = TW'(TMRD);
            CmdRefr: delay = TW'(TRFC);
            CmdPrec: delay = TW'(TRP);
            CmdActv: delay = TW'(TRCD);
            CmdWrit: delay = ddl_seq_i ? TW'(TCCD) : TW'(TWRP);
            CmdRead: delay = ddl_seq_i ? TW'(TCCD) : TW'(TRDP);
            CmdZqcl: delay = TW'(TZQ);
            default: delay = TW'(1);
        endcase
    end

    // Stall FSM: state register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StReady;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StReady: begin
                if (accept && (delay > TW'(1))) begin
                    state_d = StWait;
                    cnt_d   = delay - TW'(1);
                end
            end
            StWait: begin
                cnt_d = cnt_q - TW'(1);
                if (cnt_q <= TW'(1)) begin
                    state_d = StReady;
                end
            end
            default: state_d = StReady;
        endcase
    end

    // Ready is registered from the next state so it never sees a combinational input path.
    always_comb begin
        rdy_d = (state_d == StReady);
    end

    always_comb begin
        cs_n_d = 1'b0;
        pins_d = accept ? ddl_cmd_i : CmdNoop;
        ba_d   = accept ? ddl_ba_i : ba_q;
        adr_d  = accept ? ddl_adr_i : adr_q;
        wr_d   = accept && (ddl_cmd_i == CmdWrit);
        rd_d   = accept && (ddl_cmd_i == CmdRead);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cs_n_q <= 1'b1;
            pins_q <= CmdNoop;
            ba_q   <= '0;
            adr_q  <= '0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
        end else begin
            cs_n_q <= cs_n_d;
            pins_q <= pins_d;
            ba_q   <= ba_d;
            adr_q  <= adr_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
        end
    end

    // Wrap is registered; the pending count applies it one cycle after the interval rolls over.
    always_comb begin
        wrap_d = ref_en_i && (ref_cnt_q == RW'(TREFI - 1));
        if (!ref_en_i || wrap_d) begin
            ref_cnt_d = '0;
        end else begin
            ref_cnt_d = ref_cnt_q + RW'(1);
        end

        pend_d = pend_q;
        err_d  = err_q;
        if (wrap_q && !refr_acc) begin
            if (pend_q == PW'(PMax)) begin
                err_d = 1'b1;
            end else begin
                pend_d = pend_q + PW'(1);
            end
        end else if (refr_acc && !wrap_q && (pend_q != '0)) begin
            pend_d = pend_q - PW'(1);
        end
        ref_d = (pend_d != '0);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ref_cnt_q <= '0;
            wrap_q    <= 1'b0;
            pend_q    <= '0;
            ref_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            wrap_q    <= wrap_d;
            pend_q    <= pend_d;
            ref_q     <= ref_d;
            err_q     <= err_d;
        end
    end

    assign ddl_rdy_o   = rdy_q;
    assign ddl_ref_o   = ref_q;
    assign ref_err_o   = err_q;
    assign dfi_cs_n_o  = cs_n_q;
    assign dfi_ras_n_o = pins_q[2];
    assign dfi_cas_n_o = pins_q[1];
    assign dfi_we_n_o  = pins_q[0];
    assign dfi_ba_o    = ba_q;
    assign dfi_adr_o   = adr_q;
    assign ddl_wr_o    = wr_q;
    assign ddl_rd_o    = rd_q;

endmodule

// File: tb/tb_ddr3_ddl_cmd.sv
// Directed bench for ddr3_ddl_cmd: command latency, stall lengths, refresh tracking, reset abort.
module tb_ddr3_ddl_cmd;

    localparam logic [2:0] CMODE = 3'b000;
    localparam logic [2:0] CREFR = 3'b001;
    localparam logic [2:0] CPREC = 3'b010;
    localparam logic [2:0] CACTV = 3'b011;
    localparam logic [2:0] CWRIT = 3'b100;
    localparam logic [2:0] CREAD = 3'b101;
    localparam logic [2:0] CZQCL = 3'b110;
    localparam logic [2:0] CNOOP = 3'b111;

`ifdef DDR3_REF_POSTPONE_EN
    localparam int ErrWrap = 9;
`else
    localparam int ErrWrap = 2;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ref_en_i = 1'b0;
    logic        ddl_req_i = 1'b0;
    logic        ddl_seq_i = 1'b0;
    logic [2:0]  ddl_cmd_i = 3'b111;
    logic [2:0]  ddl_ba_i = 3'd0;
    logic [12:0] ddl_adr_i = 13'd0;
    logic        ddl_rdy_o, ddl_ref_o, ref_err_o;
    logic        dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o;
    logic [2:0]  dfi_ba_o;
    logic [12:0] dfi_adr_o;
    logic        ddl_wr_o, ddl_rd_o;
    logic [2:0]  pins;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;

    always #5 clock = ~clock;
    assign pins = {dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o};

    ddr3_ddl_cmd dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .ref_en_i    (ref_en_i),
        .ddl_req_i   (ddl_req_i),
        .ddl_seq_i   (ddl_seq_i),
        .ddl_rdy_o   (ddl_rdy_o),
        .ddl_ref_o   (ddl_ref_o),
        .ddl_cmd_i   (ddl_cmd_i),
        .ddl_ba_i    (ddl_ba_i),
        .ddl_adr_i   (ddl_adr_i),
        .dfi_cs_n_o  (dfi_cs_n_o),
        .dfi_ras_n_o (dfi_ras_n_o),
        .dfi_cas_n_o (dfi_cas_n_o),
        .dfi_we_n_o  (dfi_we_n_o),
        .dfi_ba_o    (dfi_ba_o),
        .dfi_adr_o   (dfi_adr_o),
        .ddl_wr_o    (ddl_wr_o),
        .ddl_rd_o    (ddl_rd_o),
        .ref_err_o   (ref_err_o)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic tick_to(input int t);
        while (cyc - t0 < t) tick();
    endtask

    // Present one command in the current cycle; returns in the cycle after the accept.
    task automatic issue(input string tag, input logic [2:0] cmd, input logic seq,
                         input logic [2:0] ba, input logic [12:0] adr);
        check({tag, "_rdy_pre"}, 32'(ddl_rdy_o), 1);
        ddl_req_i = 1'b1;
        ddl_cmd_i = cmd;
        ddl_seq_i = seq;
        ddl_ba_i  = ba;
        ddl_adr_i = adr;
        tick();
        ddl_req_i = 1'b0;
        ddl_cmd_i = CNOOP;
        ddl_seq_i = 1'b0;
    endtask

    task automatic stall_len(input string tag, input int exp);
        int n = 0;
        while (ddl_rdy_o !== 1'b1 && n < 600) begin
            tick();
            n++;
        end
        check(tag, n, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdy"}, 32'(ddl_rdy_o), 0);
        check({tag, "_ref"}, 32'(ddl_ref_o), 0);
        check({tag, "_err"}, 32'(ref_err_o), 0);
        check({tag, "_cs"}, 32'(dfi_cs_n_o), 1);
        check({tag, "_pins"}, 32'(pins), 7);
        check({tag, "_ba"}, 32'(dfi_ba_o), 0);
        check({tag, "_adr"}, 32'(dfi_adr_o), 0);
        check({tag, "_wrrd"}, 32'({ddl_wr_o, ddl_rd_o}), 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        check_reset_vals("rst");
        reset_n = 1'b1;
        tick();
        check("rst_rel_rdy", 32'(ddl_rdy_o), 1);
        check("rst_rel_cs", 32'(dfi_cs_n_o), 0);

        // ACTV accepted, READ presented while stalled
        ddl_req_i = 1'b1; ddl_cmd_i = CACTV; ddl_ba_i = 3'd3; ddl_adr_i = 13'h123;
        tick();
        check("t1_rdy_n1", 32'(ddl_rdy_o), 0);
        check("t1_pins_n1", 32'(pins), 3);
        check("t1_ba_n1", 32'(dfi_ba_o), 3);
        check("t1_adr_n1", 32'(dfi_adr_o), 32'h123);
        ddl_cmd_i = CREAD; ddl_adr_i = 13'h040;
        tick();
        check("t1_rdy_n2", 32'(ddl_rdy_o), 1);
        check("t1_nop_n2", 32'(pins), 7);
        check("t1_adr_hold", 32'(dfi_adr_o), 32'h123);
        check("t1_rd_n2", 32'(ddl_rd_o), 0);
        tick();
        ddl_req_i = 1'b0; ddl_cmd_i = CNOOP;
        check("t1_pins_n3", 32'(pins), 5);
        check("t1_adr_n3", 32'(dfi_adr_o), 32'h040);
        check("t1_rd_n3", 32'(ddl_rd_o), 1);
        check("t1_rdy_n3", 32'(ddl_rdy_o), 0);
        tick();
        check("t1_rd_pulse", 32'(ddl_rd_o), 0);
        check("t1_nop_n4", 32'(pins), 7);
        stall_len("t1_trdp", 4);

        // Burst then auto-precharge, READ and WRIT
        issue("rd_seq", CREAD, 1'b1, 3'd1, 13'h008);
        stall_len("rd_tccd", 3);
        issue("rd_ap", CREAD, 1'b0, 3'd1, 13'h410);
        stall_len("rd_trdp", 5);
        issue("rd_actv", CACTV, 1'b0, 3'd1, 13'h0ff);
        stall_len("rd_trcd", 1);
        issue("wr_seq", CWRIT, 1'b1, 3'd2, 13'h010);
        check("wr_pins", 32'(pins), 4);
        check("wr_pulse", 32'(ddl_wr_o), 1);
        check("wr_nord", 32'(ddl_rd_o), 0);
        stall_len("wr_tccd", 3);
        issue("wr_ap", CWRIT, 1'b0, 3'd2, 13'h418);
        stall_len("wr_twrp", 12);
        issue("wr_actv", CACTV, 1'b0, 3'd2, 13'h001);
        stall_len("wr_trcd", 1);
        issue("prec", CPREC, 1'b0, 3'd0, 13'h400);
        check("prec_pins", 32'(pins), 2);
        stall_len("prec_trp", 1);
        issue("mode", CMODE, 1'b0, 3'd2, 13'h018);
        check("mode_pins", 32'(pins), 0);
        stall_len("mode_tmrd", 3);
        issue("noop1", CNOOP, 1'b0, 3'd5, 13'h155);
        check("noop1_adr", 32'(dfi_adr_o), 32'h155);
        issue("noop2", CNOOP, 1'b0, 3'd6, 13'h0aa);
        check("noop2_rdy", 32'(ddl_rdy_o), 1);
        check("noop2_ba", 32'(dfi_ba_o), 6);

        // Refresh interval
        t0 = cyc;
        ref_en_i = 1'b1;
        tick_to(780);
        check("ref_780", 32'(ddl_ref_o), 0);
        tick_to(781);
        check("ref_781", 32'(ddl_ref_o), 1);
        check("ref_rdy_ungated", 32'(ddl_rdy_o), 1);
        tick_to(800);
        issue("refr800", CREFR, 1'b0, 3'd0, 13'h000);
        check("ref_801", 32'(ddl_ref_o), 0);
        check("refr_pins", 32'(pins), 1);
        stall_len("refr_trfc", 10);
        tick_to(1560);
        check("ref_1560", 32'(ddl_ref_o), 0);
        tick_to(1561);
        check("ref_1561", 32'(ddl_ref_o), 1);

        // REFR in the same cycle the wrap lands: pending stays at one
        tick_to(2340);
        issue("refr_wrap", CREFR, 1'b0, 3'd0, 13'h000);
        check("simul_ref", 32'(ddl_ref_o), 1);
        tick();
        check("simul_ref2", 32'(ddl_ref_o), 1);
        check("simul_err", 32'(ref_err_o), 0);
        stall_len("simul_trfc", 9);

        // Clear pending with the timer off, then let it overflow
        ref_en_i = 1'b0;
        issue("refr_clr", CREFR, 1'b0, 3'd0, 13'h000);
        check("clr_ref", 32'(ddl_ref_o), 0);
        stall_len("clr_trfc", 10);
        t0 = cyc;
        ref_en_i = 1'b1;
        tick_to(ErrWrap * 780);
        check("ovf_pre", 32'(ref_err_o), 0);
        tick_to(ErrWrap * 780 + 1);
        check("ovf_set", 32'(ref_err_o), 1);
        tick_to(9 * 780 + 5);
        check("ovf_sticky", 32'(ref_err_o), 1);
        check("ovf_ref", 32'(ddl_ref_o), 1);

        // Reset in the middle of a ZQCL wait
        ref_en_i = 1'b0;
        issue("zqcl", CZQCL, 1'b0, 3'd4, 13'h400);
        tick();
        tick();
        tick();
        check("zq_stall", 32'(ddl_rdy_o), 0);
        reset_n = 1'b0;
        tick();
        check_reset_vals("zq_rst");
        reset_n = 1'b1;
        tick();
        check("zq_rel_rdy", 32'(ddl_rdy_o), 1);
        issue("post_noop", CNOOP, 1'b0, 3'd0, 13'h000);
        check("post_noop_rdy", 32'(ddl_rdy_o), 1);
        issue("post_actv", CACTV, 1'b0, 3'd7, 13'h1ff);
        stall_len("post_trcd", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr3_ddl_cmd.md
# ddr3_ddl_cmd

Command-side responder for the DDR Data-Layer (DDL) request interface driven by the DDR3 controller FSM. It accepts one command per `ddl_req_i && ddl_rdy_o` handshake and enforces per-command DDR3 timing by stalling `ddl_rdy_o`. It drives registered DFI command pins and generates periodic refresh requests on `ddl_ref_o`. The block sits between the controller FSM and the DFI/PHY command path.

## Interface
- `TRCD`, 2: cycles from ACTIVATE to the next command.
- `TRP`, 2: cycles from PRECHARGE to the next command.
- `TRFC`, 11: cycles from REFRESH to the next command.
- `TMRD`, 4: cycles from MODE to the next command.
- `TZQ`, 512: cycles from ZQCL to the next command.
- `TCCD`, 4: cycles from READ/WRITE with `seq=1` to the next command.
- `TRDP`, 6: cycles from READ with `seq=0` to the next command.
- `TWRP`, 13: cycles from WRITE with `seq=0` to the next command.
- `TREFI`, 780: refresh interval, in cycles.
- `DDR_ROW_BITS`, 13: address width.
- `clock` in 1: the single clock.
- `reset_n` in 1: synchronous, active-low reset.
- `ref_en_i` in 1: enables the refresh interval timer; asserted after init completes.
- `ddl_req_i` in 1: command valid.
- `ddl_seq_i` in 1: a same-row RD/WR follows.
- `ddl_rdy_o` out 1: command can be accepted this cycle.
- `ddl_ref_o` out 1: refresh pending.
- `ddl_cmd_i` in 3: command code, encoded as {ras_n, cas_n, we_n}.
  - MODE=000, REFR=001, PREC=010, ACTV=011.
  - WRIT=100, READ=101, ZQCL=110, NOOP=111.
- `ddl_ba_i` in 3: bank address.
- `ddl_adr_i` in DDR_ROW_BITS: row/column address; bit 10 is the auto-precharge/all-bank flag.
- `dfi_cs_n_o`, `dfi_ras_n_o`, `dfi_cas_n_o`, `dfi_we_n_o` out 1 each: DFI command pins.
- `dfi_ba_o` out 3: DFI bank address.
- `dfi_adr_o` out DDR_ROW_BITS: DFI address.
- `ddl_wr_o`, `ddl_rd_o` out 1: one-cycle notifications to the data path.
- `ref_err_o` out 1: sticky refresh-overflow flag.

## Operation
- **Accept:** a command is accepted in cycle N when `ddl_req_i && ddl_rdy_o`.
  - Cycle N+1: `{ras_n,cas_n,we_n}` equals `ddl_cmd_i`, `dfi_ba_o`/`dfi_adr_o` equal the inputs, and `cs_n`=0.
  - Any cycle without an accept drives NOP: `cs_n`=0, 111, and ba/adr hold their last values.
- **Delay D per accepted command:**
  - ACTV=TRCD, PREC=TRP, REFR=TRFC, MODE=TMRD, ZQCL=TZQ.
  - READ: TCCD if `seq` else TRDP.
  - WRIT: TCCD if `seq` else TWRP.
  - NOOP: 1.
- **Stall timer:** after an accept at N with D>1, `ddl_rdy_o`=0 for cycles N+1..N+D-1 and returns to 1 at N+D. The timer is ceil(log2(max D))+1 bits.
- **State machine:**
  - READY: rdy=1. An accept with D>1 moves to WAIT.
  - WAIT: the counter decrements each cycle; at count 1 it returns to READY.
- **Data-path notify:** `ddl_wr_o`/`ddl_rd_o` pulse in cycle N+1 for an accepted WRIT/READ.
- **Refresh timer:** counts 0..TREFI-1 while `ref_en_i`=1.
  - Wrap adds 1 pending refresh.
  - An accepted REFR subtracts 1.
  - A simultaneous wrap and REFR accept leaves the pending count unchanged.
  - `ddl_ref_o` = (pending != 0), registered.
  - An increment at the maximum sets `ref_err_o` (sticky until reset) and saturates the count.
  - `ref_en_i`=0 clears the interval counter but not the pending count.
  - A REFR accepted with pending=0 is legal and does not underflow.
- **Refresh does not gate `ddl_rdy_o`:** the FSM must be able to finish a burst before it can return to idle and issue REFR.

## Timing
- **Reset (`reset_n`=0 at an edge):**
  - `ddl_rdy_o`=0, `ddl_ref_o`=0, `ref_err_o`=0.
  - `dfi_cs_n_o`=1, ras/cas/we=1, `dfi_ba_o`=0, `dfi_adr_o`=0.
  - `ddl_wr_o`=0, `ddl_rd_o`=0.
  - Timers and pending count cleared; state READY.
- **After reset:** `ddl_rdy_o`=1 in the first cycle after `reset_n` is sampled high.
- **Reset mid-WAIT:** aborts the wait. No output glitch beyond the reset values.
- **Latency:** command to pins is 1 cycle.
- **Rdy path:** `ddl_rdy_o` depends only on registered state (no combinational input-to-output path).
- **Back-to-back:** with D=1, commands are accepted every cycle.

## Configuration
- **`DDR3_REF_POSTPONE_EN` defined:** pending count is 4 bits, max 8 (JEDEC postponement). `ref_err_o` sets on a wrap while pending=8.
- **Undefined:** pending is a single flag (max 1). `ref_err_o` sets on a wrap while the flag is already set.

## Test plan
- **ACTV then READ:** ACTV accepted at cycle 10, READ presented from cycle 10 with default parameters -> rdy=0 in cycle 11, READ accepted at 12; pins show 011 at 11 and 101 at 13; `ddl_rd_o` pulses at 13.
- **Burst vs auto-precharge:** READ with seq=1 at cycle 0, then READ with seq=0 at cycle 4 -> accepts at 0 and 4; the next ACTV is accepted no earlier than cycle 10 (TRDP=6). The same pattern for WRIT gives the next ACTV at cycle 17.
- **Refresh interval:** `ref_en_i`=1 at cycle 0, no REFR issued -> `ddl_ref_o` rises at cycle 781. REFR accepted at 800 -> `ddl_ref_o`=0 at 801 and rdy=0 until cycle 811.
- **Overflow:** `ref_en_i` high for 9×780 cycles with no REFR -> with the macro, `ref_err_o` rises after the 9th wrap; without it, after the 2nd wrap; the flag stays high.
- **Simultaneous wrap and REFR:** pending=1 and REFR accepted in the wrap cycle -> pending stays 1 and `ddl_ref_o` stays high.
- **Reset mid-WAIT:** `reset_n` low during a TZQ=512 wait -> all reset values next cycle; rdy=1 one cycle after release; no residual stall.
